reg_file: RTL and testbench

Architectural integer register file for the RV32I_Zicsr core, with a per-register pending-write scoreboard. It is the receiving end of the write-back stage's rd write interface: it commits rd writes and serves two combinational read ports to decode, with write-to-read bypass. It tracks in-flight writers per register and raises a stall when decode would read a value not yet written back.

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_scoreboard.sv | 82 ++++++++
 rtl/reg_file.sv | 73 +++++++
 tb/tb_reg_file.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and sizes for the RV32I_Zicsr integer register file and its scoreboard.
package reg_file_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 32;
  localparam int unsigned PCNT_W = 2;

endpackage : reg_file_pkg

// File: rtl/reg_scoreboard.sv
// Per-register pending-writer counters with flush, plus the decode hazard and structural stall.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned XADDR = ADDR_W,
  parameter int unsigned PCNTW = PCNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic             i_rd_write,
  input  logic [XADDR-1:0] i_rs1_addr,
  input  logic             i_rs1_read,
  input  logic [XADDR-1:0] i_rs2_addr,
  input  logic             i_rs2_read,
  input  logic             i_issue,
  input  logic [XADDR-1:0] i_issue_rd,
  input  logic             i_issue_write,
  input  logic             i_flush,
  output logic             o_stall
);

  localparam int unsigned NR = 1 << XADDR;
  localparam logic [PCNTW-1:0] PMAX = '1;
  localparam logic [PCNTW-1:0] PONE = PCNTW'(1);

  logic [PCNTW-1:0] pend_q [NR];
  logic [PCNTW-1:0] pend_d [NR];

  logic haz1_c;
  logic haz2_c;
  logic struct_c;
  logic issue_ok_c;
  logic retire_c;

  // A single outstanding writer landing this cycle is forwarded by the bypass, so no hazard.
  always_comb begin
    haz1_c   = i_rs1_read && (i_rs1_addr != '0) && (pend_q[i_rs1_addr] != '0) &&
               !((pend_q[i_rs1_addr] == PONE) && i_rd_write && (i_rd_addr == i_rs1_addr));
    haz2_c   = i_rs2_read && (i_rs2_addr != '0) && (pend_q[i_rs2_addr] != '0) &&
               !((pend_q[i_rs2_addr] == PONE) && i_rd_write && (i_rd_addr == i_rs2_addr));
    struct_c = i_issue_write && (i_issue_rd != '0) && (pend_q[i_issue_rd] == PMAX);
  end

  assign o_stall    = i_issue && (haz1_c || haz2_c || struct_c);
  assign issue_ok_c = i_issue && !o_stall && i_issue_write && (i_issue_rd != '0);
  assign retire_c   = i_rd_write && (i_rd_addr != '0) && (pend_q[i_rd_addr] != '0);

  // Issue and retire on the same register cancel; flush wins over both.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned r = 0; r < NR; r++) begin
      if (i_flush || (r == 0)) begin
        pend_d[r] = '0;
      end else if (issue_ok_c && (i_issue_rd == XADDR'(r)) &&
                   !(retire_c && (i_rd_addr == XADDR'(r)))) begin
        pend_d[r] = pend_q[r] + PONE;
      end else if (retire_c && (i_rd_addr == XADDR'(r)) &&
                   !(issue_ok_c && (i_issue_rd == XADDR'(r)))) begin
        pend_d[r] = pend_q[r] - PONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < NR; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      pend_q <= pend_d;
    end
  end

  // The structural stall must keep every counter from wrapping.
  always @(posedge i_clk) begin
    if (i_rst_n && issue_ok_c) begin
      assert (pend_q[i_issue_rd] != PMAX);
    end
  end

endmodule : reg_scoreboard

// File: rtl/reg_file.sv
// Integer register file: storage array, write-to-read bypass read ports and pending-writer scoreboard.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned XLEN  = DATA_W,
  parameter int unsigned XADDR = ADDR_W,
  parameter int unsigned PCNTW = PCNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic             i_rd_write,
  input  logic [XLEN-1:0]  i_rd_data,
  input  logic [XADDR-1:0] i_rs1_addr,
  input  logic             i_rs1_read,
  input  logic [XADDR-1:0] i_rs2_addr,
  input  logic             i_rs2_read,
  input  logic             i_issue,
  input  logic [XADDR-1:0] i_issue_rd,
  input  logic             i_issue_write,
  input  logic             i_flush,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data,
  output logic             o_stall
);

  localparam int unsigned NR = 1 << XADDR;

  logic [XLEN-1:0] regs_q [NR];
  logic            wr_en_c;

  assign wr_en_c = i_rd_write && (i_rd_addr != '0);

  // Entry 0 is held at zero by never being written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < NR; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[i_rd_addr] <= i_rd_data;
    end
  end

  always_comb begin
    o_rs1_data = regs_q[i_rs1_addr];
    o_rs2_data = regs_q[i_rs2_addr];
    if (wr_en_c && (i_rd_addr == i_rs1_addr)) o_rs1_data = i_rd_data;
    if (wr_en_c && (i_rd_addr == i_rs2_addr)) o_rs2_data = i_rd_data;
    if (i_rs1_addr == '0) o_rs1_data = '0;
    if (i_rs2_addr == '0) o_rs2_data = '0;
  end

  reg_scoreboard #(
    .XADDR (XADDR),
    .PCNTW (PCNTW)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rd_addr     (i_rd_addr),
    .i_rd_write    (i_rd_write),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs1_read    (i_rs1_read),
    .i_rs2_addr    (i_rs2_addr),
    .i_rs2_read    (i_rs2_read),
    .i_issue       (i_issue),
    .i_issue_rd    (i_issue_rd),
    .i_issue_write (i_issue_write),
    .i_flush       (i_flush),
    .o_stall       (o_stall)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file against an array/counter reference model.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr;
  logic        rd_write;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic        rs1_read;
  logic [4:0]  rs2_addr;
  logic        rs2_read;
  logic        issue;
  logic [4:0]  issue_rd;
  logic        issue_write;
  logic        flush;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;

  int checks;
  int failures;

  logic [31:0] m_reg  [32];
  int          m_pend [32];

  reg_file dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rd_addr     (rd_addr),
    .i_rd_write    (rd_write),
    .i_rd_data     (rd_data),
    .i_rs1_addr    (rs1_addr),
    .i_rs1_read    (rs1_read),
    .i_rs2_addr    (rs2_addr),
    .i_rs2_read    (rs2_read),
    .i_issue       (issue),
    .i_issue_rd    (issue_rd),
    .i_issue_write (issue_write),
    .i_flush       (flush),
    .o_rs1_data    (rs1_data),
    .o_rs2_data    (rs2_data),
    .o_stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (rd_write && rd_addr == a) return rd_data;
    return m_reg[a];
  endfunction

  function automatic bit m_haz(input logic rd, input logic [4:0] a);
    if (!rd || a == 0 || m_pend[a] == 0) return 1'b0;
    // exactly one writer outstanding and it is landing now: value comes via bypass
    if (m_pend[a] == 1 && rd_write && rd_addr == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    bit full;
    full = issue_write && issue_rd != 0 && m_pend[issue_rd] >= 3;
    return issue && (m_haz(rs1_read, rs1_addr) || m_haz(rs2_read, rs2_addr) || full);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin
      m_reg[r]  = 32'h0;
      m_pend[r] = 0;
    end
  endtask

  task automatic idle();
    rd_addr = 0; rd_write = 0; rd_data = 0;
    rs1_addr = 0; rs1_read = 0; rs2_addr = 0; rs2_read = 0;
    issue = 0; issue_rd = 0; issue_write = 0; flush = 0;
  endtask

  // Compare all outputs with the model while inputs are stable, mid-cycle.
  task automatic settle();
    #1;
    chk("rs1_data", rs1_data, m_read(rs1_addr));
    chk("rs2_data", rs2_data, m_read(rs2_addr));
    chk("stall", 32'(stall), 32'(m_stall()));
  endtask

  // Cross the rising edge, update the model, return at the next falling edge.
  task automatic adv();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      if (rd_write && rd_addr != 0) m_reg[rd_addr] = rd_data;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
      end else begin
        if (rd_write && rd_addr != 0 && m_pend[rd_addr] > 0) m_pend[rd_addr]--;
        if (issue && !st && issue_write && issue_rd != 0) m_pend[issue_rd]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_issue(input logic [4:0] r);
    idle(); issue = 1; issue_write = 1; issue_rd = r;
    settle(); adv();
  endtask

  task automatic do_wb(input logic [4:0] r, input logic [31:0] d);
    idle(); rd_write = 1; rd_addr = r; rd_data = d;
    settle(); adv();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state and x0
    idle(); rs1_addr = 5; rs1_read = 1; rs2_addr = 0; rs2_read = 1;
    settle();
    chk("reset_x5", rs1_data, 32'h0);
    chk("reset_x0", rs2_data, 32'h0);
    adv();
    idle(); rd_write = 1; rd_addr = 0; rd_data = 32'hDEADBEEF; rs1_addr = 0;
    settle(); adv();
    idle(); rs1_addr = 0;
    settle(); chk("x0_ignore", rs1_data, 32'h0); adv();

    // bypass then array
    idle(); rd_write = 1; rd_addr = 3; rd_data = 32'h12345678; rs1_addr = 3; rs1_read = 1;
    settle(); chk("bypass_x3", rs1_data, 32'h12345678); adv();
    idle(); rs1_addr = 3; rs1_read = 1;
    settle(); chk("array_x3", rs1_data, 32'h12345678); adv();

    // RAW hazard on x7
    do_issue(7);
    for (int i = 0; i < 2; i++) begin
      idle(); issue = 1; rs2_addr = 7; rs2_read = 1;
      settle(); chk("raw_x7_stall", 32'(stall), 32'd1); adv();
    end
    idle(); issue = 1; rs2_addr = 7; rs2_read = 1;
    rd_write = 1; rd_addr = 7; rd_data = 32'hA5A5A5A5;
    settle();
    chk("raw_x7_release", 32'(stall), 32'd0);
    chk("raw_x7_data", rs2_data, 32'hA5A5A5A5);
    adv();

    // structural stall on x9
    for (int i = 0; i < 3; i++) do_issue(9);
    idle(); issue = 1; issue_write = 1; issue_rd = 9;
    settle(); chk("full_x9", 32'(stall), 32'd1); adv();
    idle(); issue = 1; issue_write = 1; issue_rd = 9;
    rd_write = 1; rd_addr = 9; rd_data = 32'h1;
    settle(); chk("full_x9_retire", 32'(stall), 32'd1); adv();
    idle(); issue = 1; issue_write = 1; issue_rd = 9;
    settle(); chk("x9_reissue", 32'(stall), 32'd0); adv();
    chk("x9_count3", 32'(m_pend[9]), 32'd3);
    for (int i = 0; i < 2; i++) begin
      idle(); issue = 1; rs1_addr = 9; rs1_read = 1;
      rd_write = 1; rd_addr = 9; rd_data = 32'h100 + 32'(i);
      settle(); chk("x9_multi_stall", 32'(stall), 32'd1); adv();
    end
    do_wb(9, 32'h200);

    // flush with simultaneous issue
    do_issue(4);
    do_issue(6);
    idle(); flush = 1; issue = 1; issue_write = 1; issue_rd = 8;
    settle(); adv();
    idle(); issue = 1; rs1_addr = 4; rs1_read = 1; rs2_addr = 6; rs2_read = 1;
    settle(); chk("flush_x4_x6", 32'(stall), 32'd0); adv();
    idle(); issue = 1; rs1_addr = 8; rs1_read = 1;
    settle(); chk("flush_x8", 32'(stall), 32'd0); adv();
    do_wb(4, 32'h44444444);

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      idle();
      rd_write    = ($urandom_range(0, 9) < 4);
      rd_addr     = 5'($urandom_range(0, 7));
      rd_data     = $urandom();
      rs1_addr    = 5'($urandom_range(0, 7));
      rs1_read    = 1'($urandom_range(0, 1));
      rs2_addr    = 5'($urandom_range(0, 7));
      rs2_read    = 1'($urandom_range(0, 1));
      issue       = ($urandom_range(0, 9) < 6);
      issue_rd    = 5'($urandom_range(0, 7));
      issue_write = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 99) < 3);
      settle();
      adv();
    end

    // asynchronous reset in the middle of a stall
    do_issue(10);
    idle(); issue = 1; rs1_addr = 10; rs1_read = 1; rs2_addr = 3; rs2_read = 1;
    settle(); chk("pre_reset_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_rs1", rs1_data, 32'h0);
    chk("async_rst_rs2", rs2_data, 32'h0);
    adv();
    rst_n = 1'b1;
    idle(); issue = 1; rs1_addr = 10; rs1_read = 1;
    settle(); chk("post_reset_stall", 32'(stall), 32'd0); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule : tb_reg_file
